// File: rtl/hash_byte_packer_pkg.sv
// Shared constants for the hash byte packer: coefficient and counter
// widths, message sizes, FSM state encoding and a byte-mask helper.
package hash_byte_packer_pkg;

   localparam int COEF_W  = 13;
   localparam int CNT_W   = 11;
   localparam int P       = 757;
   localparam int BYTES_P = 1231;

   // Accumulator holds up to 7 leftover bits plus one full coefficient.
   localparam int ACC_W = COEF_W + 8;
   localparam int NB_W  = 5;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;
   localparam logic [1:0] FIN   = 2'd3;

   // Mask keeping only the low n bits of a byte (all ones for n >= 8).
   function automatic logic [7:0] low_mask(input logic [NB_W-1:0] n);
      logic [8:0] m;
      if (n >= NB_W'(8)) begin
         m = 9'h0ff;
      end else begin
         m = (9'd1 << n[2:0]) - 9'd1;
      end
      return m[7:0];
   endfunction

endpackage

// File: rtl/hash_byte_packer_fsm.sv
// Controller for the hash byte packer: state register plus handshake
// and datapath-control decode.
// Ports: clk/rst; start, deg_zero; datapath status flags (cnt_done,
//   nb_lt8, nb_zero); coef_valid/byte_ready in; coef_ready/byte_valid
//   out; load/accept/emit/flush strobes to the datapath; busy, done.
module hash_byte_packer_fsm (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic deg_zero,
   input  logic cnt_done,
   input  logic nb_lt8,
   input  logic nb_zero,
   input  logic coef_valid,
   input  logic byte_ready,
   output logic coef_ready,
   output logic byte_valid,
   output logic load,
   output logic accept,
   output logic emit,
   output logic flush,
   output logic busy,
   output logic done
);
   import hash_byte_packer_pkg::*;

   logic [1:0] state;
   logic [1:0] nxt;

   always_comb begin
      coef_ready = (state == RUN) && nb_lt8 && !cnt_done;
      byte_valid = ((state == RUN) && !nb_lt8)
                || ((state == FLUSH) && !nb_zero);
      load       = (state == IDLE) && start;
      accept     = coef_valid && coef_ready;
      emit       = byte_valid && byte_ready;
      flush      = (state == FLUSH);
      busy       = (state != IDLE);
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               nxt = deg_zero ? FIN : RUN;
            end
         end
         RUN: begin
            if (cnt_done && nb_lt8) begin
               nxt = FLUSH;
            end
         end
         FLUSH: begin
            if (nb_zero || emit) begin
               nxt = FIN;
            end
         end
         FIN: begin
            nxt = IDLE;
         end
         default: begin
            nxt = IDLE;
         end
      endcase
   end

   // done is registered so it rises the cycle FIN hands back to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         state <= nxt;
         done  <= (state == FIN);
      end
   end

endmodule

// File: rtl/hash_byte_packer.sv
// Packs 13-bit coefficients LSB-first into a little-endian byte stream
// for the SHA-512 input buffer; final byte is zero-padded.
// Ports: clk, rst (sync, active-high); start/degp begin a message;
//   coef_in/coef_valid/coef_ready input stream; byte_out/byte_valid/
//   byte_ready output stream; byte_count, busy, done status.
module hash_byte_packer #(
   parameter int COEF_W = hash_byte_packer_pkg::COEF_W,
   parameter int CNT_W  = hash_byte_packer_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  degp,
   input  logic [COEF_W-1:0] coef_in,
   input  logic              coef_valid,
   output logic              coef_ready,
   output logic [7:0]        byte_out,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic [CNT_W-1:0]  byte_count,
   output logic              busy,
   output logic              done
);
   import hash_byte_packer_pkg::*;

   localparam int AW = COEF_W + 8;

   logic [AW-1:0]    acc;
   logic [NB_W-1:0]  nb;
   logic [CNT_W-1:0] coef_cnt;
   logic [CNT_W-1:0] deg_q;
   logic [CNT_W-1:0] byte_cnt;

   logic load;
   logic accept;
   logic emit;
   logic flush;
   logic cnt_done;
   logic nb_lt8;
   logic nb_zero;
   logic deg_zero;

   assign cnt_done = (coef_cnt == deg_q);
   assign nb_lt8   = (nb < NB_W'(8));
   assign nb_zero  = (nb == '0);
   assign deg_zero = (degp == '0);

   hash_byte_packer_fsm u_fsm (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .deg_zero   (deg_zero),
      .cnt_done   (cnt_done),
      .nb_lt8     (nb_lt8),
      .nb_zero    (nb_zero),
      .coef_valid (coef_valid),
      .byte_ready (byte_ready),
      .coef_ready (coef_ready),
      .byte_valid (byte_valid),
      .load       (load),
      .accept     (accept),
      .emit       (emit),
      .flush      (flush),
      .busy       (busy),
      .done       (done)
   );

   // Bits above nb are already zero; the mask keeps the padded final
   // byte clean even if that invariant is ever broken upstream.
   assign byte_out   = acc[7:0] & low_mask(nb);
   assign byte_count = byte_cnt;

   // accept needs nb<8 and emit needs nb>=8 (or FLUSH), so at most one
   // of them fires in any cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         nb       <= '0;
         coef_cnt <= '0;
         deg_q    <= '0;
         byte_cnt <= '0;
      end else if (load) begin
         acc      <= '0;
         nb       <= '0;
         coef_cnt <= '0;
         deg_q    <= degp;
         byte_cnt <= '0;
      end else if (accept) begin
         acc      <= acc | (AW'(coef_in) << nb);
         nb       <= nb + NB_W'(COEF_W);
         coef_cnt <= coef_cnt + 1'b1;
      end else if (emit && flush) begin
         acc      <= '0;
         nb       <= '0;
         byte_cnt <= byte_cnt + 1'b1;
      end else if (emit) begin
         acc      <= acc >> 8;
         nb       <= nb - NB_W'(8);
         byte_cnt <= byte_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hash_byte_packer.sv
// Randomized self-checking bench for hash_byte_packer against a
// bit-list packing reference model.
module tb_hash_byte_packer;
   import hash_byte_packer_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic [10:0] degp;
   logic [12:0] coef_in;
   logic        coef_valid;
   logic        coef_ready;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready;
   logic [10:0] byte_count;
   logic        busy;
   logic        done;

   int tests;
   int fails;

   logic [12:0] coefs[$];
   logic [7:0]  expb[$];

   hash_byte_packer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .degp       (degp),
      .coef_in    (coef_in),
      .coef_valid (coef_valid),
      .coef_ready (coef_ready),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .byte_count (byte_count),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: lay all coefficient bits out as one bit string, then
   // cut it into bytes, padding the tail with zeros.
   function automatic void build_ref();
      int nbits;
      int nbytes;
      int pos;
      logic [7:0] v;
      logic [12:0] c;
      expb.delete();
      nbits  = 13 * coefs.size();
      nbytes = (nbits + 7) / 8;
      for (int b = 0; b < nbytes; b++) begin
         v = 8'h00;
         for (int k = 0; k < 8; k++) begin
            pos = 8 * b + k;
            if (pos < nbits) begin
               c = coefs[pos / 13];
               v[k] = c[pos % 13];
            end
         end
         expb.push_back(v);
      end
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_coef_ready"}, 32'(coef_ready), 0);
      check({tag, "_byte_valid"}, 32'(byte_valid), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_byte_out"}, 32'(byte_out), 0);
      check({tag, "_byte_count"}, 32'(byte_count), 0);
   endtask

   task automatic run_msg(input string tag, input int rdy_pct,
                          input int vld_pct, input int abort_at);
      int n;
      int ci;
      int bi;
      int cyc;
      bit fin;
      bit prev_stall;
      logic [7:0] prev_byte;
      n = coefs.size();
      ci = 0;
      bi = 0;
      cyc = 0;
      fin = 0;
      prev_stall = 0;
      prev_byte = 8'h00;
      build_ref();
      @(negedge clk);
      start = 1'b1;
      degp = 11'(n);
      coef_valid = 1'b0;
      byte_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_start"}, 32'(busy), 1);
      while (!fin && cyc < 20000) begin
         cyc++;
         if (done) begin
            fin = 1;
            start = 1'b0;
            degp = 11'(n);
            coef_valid = 1'b0;
            byte_ready = 1'b0;
            break;
         end
         if (abort_at > 0 && ci == abort_at) begin
            start = 1'b0;
            coef_valid = 1'b0;
            byte_ready = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_reset_vals({tag, "_rst"});
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               check({tag, "_no_done"}, 32'(done), 0);
            end
            return;
         end
         // Stray starts must be ignored while a message is in flight.
         start = ($urandom_range(31) == 0);
         degp = 11'($urandom);
         if (ci < n) begin
            coef_valid = ($urandom_range(99) < vld_pct);
         end else begin
            coef_valid = 1'b1;
         end
         coef_in = (ci < n && coef_valid) ? coefs[ci] : 13'($urandom);
         byte_ready = ($urandom_range(99) < rdy_pct);
         #1;
         if (prev_stall) begin
            check({tag, "_stall_valid"}, 32'(byte_valid), 1);
            check({tag, "_stall_byte"}, 32'(byte_out), 32'(prev_byte));
         end
         if (byte_valid) begin
            check({tag, "_no_accept_bv"}, 32'(coef_ready), 0);
         end
         if (coef_ready) begin
            check({tag, "_ready_bound"}, 32'(ci < n), 1);
         end
         if (coef_valid && coef_ready && ci < n) begin
            ci++;
         end
         if (byte_valid && byte_ready) begin
            check({tag, "_overrun"}, 32'(bi < expb.size()), 1);
            if (bi < expb.size()) begin
               check($sformatf("%s_byte%0d", tag, bi),
                     32'(byte_out), 32'(expb[bi]));
            end
            bi++;
         end
         prev_stall = byte_valid && !byte_ready;
         prev_byte = byte_out;
         @(negedge clk);
      end
      check({tag, "_finished"}, 32'(fin), 1);
      check({tag, "_coefs"}, 32'(ci), 32'(n));
      check({tag, "_nbytes"}, 32'(bi), 32'(expb.size()));
      check({tag, "_byte_count"}, 32'(byte_count), 32'(expb.size()));
      @(negedge clk);
      check({tag, "_done_once"}, 32'(done), 0);
      check({tag, "_idle"}, 32'(busy), 0);
      check({tag, "_count_hold"}, 32'(byte_count), 32'(expb.size()));
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      start = 1'b0;
      degp = '0;
      coef_in = '0;
      coef_valid = 1'b0;
      byte_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;

      coefs.delete();
      coefs.push_back(13'h1ABC);
      run_msg("single", 100, 100, 0);

      coefs.delete();
      coefs.push_back(13'h1FFF);
      coefs.push_back(13'h0000);
      run_msg("two", 100, 100, 0);

      coefs.delete();
      for (int i = 0; i < P; i++) coefs.push_back(13'h1FFF);
      run_msg("full", 100, 100, 0);
      check("full_bytes_p", 32'(byte_count), BYTES_P);

      coefs.delete();
      for (int i = 0; i < P; i++) coefs.push_back(13'($urandom));
      run_msg("bp", 50, 70, 0);

      // Zero-length message: straight to FIN, done two cycles later.
      @(negedge clk);
      start = 1'b1;
      degp = '0;
      coef_valid = 1'b1;
      byte_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("zero_ready1", 32'(coef_ready), 0);
      check("zero_valid1", 32'(byte_valid), 0);
      check("zero_done1", 32'(done), 0);
      @(negedge clk);
      check("zero_ready2", 32'(coef_ready), 0);
      check("zero_valid2", 32'(byte_valid), 0);
      check("zero_done2", 32'(done), 1);
      @(negedge clk);
      check("zero_done3", 32'(done), 0);
      check("zero_count", 32'(byte_count), 0);
      coef_valid = 1'b0;
      byte_ready = 1'b0;

      coefs.delete();
      for (int i = 0; i < P; i++) coefs.push_back(13'($urandom));
      run_msg("abort", 50, 100, 100);

      coefs.delete();
      coefs.push_back(13'h0005);
      run_msg("after_rst", 100, 100, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
